flash_rd_sched: RTL and testbench
=================================

# flash_rd_sched

Quad-SPI read scheduler for the SoC's external program flash. It shares the single flash device between two requesters, port 0 (instruction fetch) and port 1 (data load), with round-robin arbitration. For each granted request it sequences one Fast-Read-Quad (0xEB) transaction on the flash pins and returns one 32-bit word. It sits between the AHB flash slave logic and the fsclk/fcen/fd pads.

## Interface
- DUMMY_CLKS, 4: number of SCK periods spent in the dummy phase (fdoe all low).
- CS_IDLE, 2: minimum HCLK cycles fcen is held high between transactions.
- HCLK  in  1  system clock. All logic is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  read request. Held high until the matching gnt.
- addr0 / addr1  in  24  byte address. Bits [1:0] are ignored and forced to 0.
- gnt0 / gnt1  out  1  one-cycle pulse. The address is captured on this cycle.
- rvalid0 / rvalid1  out  1  one-cycle pulse. rdata is valid on this cycle.
- rdata  out  32  read word, little-endian (byte at addr goes to [7:0]).
- fsclk  out  1  flash SCK, mode 0 (idles low), HCLK/2.
- fcen  out  1  flash chip enable, active low.
- fdo  out  4  flash data out.
- fdoe  out  4  per-line output enable.
- fdi  in  4  flash data in.

## Operation
- **States:** IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE, GAP.
- **IDLE:**
  - Waits for any req.
  - The arbiter picks a requester and pulses its gnt. The controller latches {addr[23:2],2'b00} and the port id, then moves to CMD.
- **Arbitration:**
  - Round robin on the last-granted pointer.
  - Reset sets the pointer to 1, so port 0 wins the first tie.
  - With only one port requesting, that port is granted every transaction.
- **CMD:** 8 SCK periods. fdoe=4'b0001. 0xEB is shifted MSB-first on fdo[0].
- **ADDR:** 6 SCK periods. fdoe=4'hF. The address is sent one nibble per period, MSB nibble first.
- **MODE:** 2 SCK periods. fdoe=4'hF. fdo=4'h0, which disables continuous-read mode.
- **DUMMY:** DUMMY_CLKS periods. fdoe=4'h0.
- **DATA:**
  - 8 SCK periods. fdoe=4'h0. One nibble is sampled per period.
  - Byte k takes its high nibble first, then its low nibble.
  - Byte k is placed in rdata[8k+7:8k].
- **DONE:**
  - fcen goes high.
  - rvalid for the latched port pulses for one cycle.
  - rdata holds its value until the next DATA phase overwrites it.
- **GAP:** CS_IDLE cycles with fcen high, then return to IDLE.
- No request is accepted outside IDLE. A req raised mid-transaction waits.

## Timing
- **SCK generation:**
  - Each SCK period is 2 HCLK: a low phase, then a high phase.
  - fsclk is forced low in IDLE, DONE and GAP.
- **Drive and sample points:**
  - fdo/fdoe change only at the HCLK edge that begins a low phase (falling SCK).
  - fdi is sampled at the HCLK edge that ends a high phase.
- **Latency:**
  - Cycle 0 = the gnt cycle.
  - fcen falls at cycle 1.
  - The transaction spans 8+6+2+DUMMY_CLKS+8 SCK periods: 56 HCLK at the default DUMMY_CLKS.
  - rvalid at cycle 57 at the default.
  - The earliest next gnt is at cycle 58+CS_IDLE (cycle 60 at the default).
- **Reset values:**
  - fcen=1, fsclk=0, fdo=0, fdoe=0.
  - gnt*=0, rvalid*=0, rdata=0.
  - State = IDLE. RR pointer = 1.
- **Reset mid-transaction:**
  - All outputs take their reset values immediately, asynchronously.
  - The aborted request receives no rvalid.
  - The requester must re-assert req after reset.
- **Simultaneous events:**
  - If both reqs are high in IDLE, exactly one gnt is asserted.
  - gnt0 and gnt1 are never high together.
  - rvalid0 and rvalid1 are never high together.

## Structure
- Package n5_flash_pkg holds:
  - the state enum;
  - CMD_QREAD=8'hEB;
  - phase lengths CMD_CLKS=8, ADDR_CLKS=6, MODE_CLKS=2, DATA_CLKS=8.
- Sub-module flash_rr_arb: the 2-way round-robin arbiter.
  - Inputs: req[1:0], enable (IDLE).
  - Outputs: one-hot gnt, port id.
- Top level holds:
  - the sequencer FSM;
  - the SCK phase toggle;
  - the period counter;
  - shift registers.

## Test plan
- **Single read:** flash word at 0x000100 = bytes 11 22 33 44; req0 with addr0=0x000102.
  - Flash sees 0xEB then address 0x000100.
  - rvalid0 at cycle 57 with rdata=32'h44332211.
- **Pin check:** during the single read, verify fcen low for exactly 56 HCLK.
  - fdoe=0001/F/F/0/0 across the five phases.
  - fsclk toggles 28 times high.
- **Tie:** req0 and req1 asserted together from reset.
  - gnt0 first, then gnt1 at cycle 60.
  - Each port receives the correct word on its own rvalid.
- **Sustained contention:** both reqs held high for 6 transactions.
  - Grants alternate 0,1,0,1,0,1.
  - fcen high ≥2 cycles between transactions.
- **Reset mid-op:** assert HRESET during the DATA phase.
  - fcen=1, fsclk=0, fdoe=0 in the same cycle.
  - No rvalid.
  - A new req0 after release completes normally.
- **Late request:** req1 rises mid-transaction.
  - gnt1 is delayed until after GAP.
  - The in-flight port's rdata is unaffected.

Source files
------------

// File: rtl/n5_flash_pkg.sv
// Shared types and constants for the quad-SPI flash read scheduler.
package n5_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        DONE,
        GAP
    } state_t;

    localparam logic [7:0] CMD_QREAD = 8'hEB;

    localparam int CMD_CLKS  = 8;
    localparam int ADDR_CLKS = 6;
    localparam int MODE_CLKS = 2;
    localparam int DATA_CLKS = 8;

    // True while chip select is asserted and SCK is running.
    function automatic logic is_active(input state_t s);
        return (s == CMD) || (s == ADDR) || (s == MODE) || (s == DUMMY) || (s == DATA);
    endfunction

endpackage

// File: rtl/flash_rd_sched_if.sv
// Requester-side bus of the flash read scheduler: two request ports and a shared read-data return.
interface flash_rd_sched_if;

    logic        req0;
    logic        req1;
    logic [23:0] addr0;
    logic [23:0] addr1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata;

    modport master (
        output req0, req1, addr0, addr1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, addr0, addr1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface

// File: rtl/flash_rr_arb.sv
// Two-way round-robin arbiter; grants are combinational and only offered while enabled.
module flash_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       port
);

    logic last;
    logic valid;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        valid = 1'b0;
        port  = 1'b0;
        if (enable) begin
            case (req)
                2'b01:   begin valid = 1'b1; port = 1'b0;  end
                2'b10:   begin valid = 1'b1; port = 1'b1;  end
                2'b11:   begin valid = 1'b1; port = ~last; end
                default: ;
            endcase
        end
    end

    assign gnt = valid ? (port ? 2'b10 : 2'b01) : 2'b00;

    // Remember the most recent winner; starting at 1 lets port 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (valid) begin
            last <= port;
        end
    end

endmodule

// File: rtl/flash_rd_sched.sv
// Quad-SPI Fast-Read-Quad (0xEB) sequencer shared by two requesters; one 32-bit word per grant.
module flash_rd_sched
    import n5_flash_pkg::*;
#(
    parameter int DUMMY_CLKS = 4,
    parameter int CS_IDLE    = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    flash_rd_sched_if.slave  bus,
    output logic             fsclk,
    output logic             fcen,
    output logic [3:0]       fdo,
    output logic [3:0]       fdoe,
    input  logic [3:0]       fdi
);

    state_t      state;
    state_t      state_n;
    logic        ph;        // 0 = SCK low phase, 1 = SCK high phase
    logic        ph_n;
    logic [7:0]  cnt;       // SCK periods within a phase, or HCLK cycles in GAP
    logic [7:0]  cnt_n;
    logic        port_q;
    logic [23:0] addr_q;
    logic [1:0]  arb_gnt;
    logic        arb_port;
    logic        arb_en;
    logic        arb_valid;
    logic [3:0]  fdo_n;
    logic [3:0]  fdoe_n;
    logic [31:0] rdata_q;

    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            CMD:     return 8'(CMD_CLKS);
            ADDR:    return 8'(ADDR_CLKS);
            MODE:    return 8'(MODE_CLKS);
            DUMMY:   return 8'(DUMMY_CLKS);
            default: return 8'(DATA_CLKS);
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            CMD:     return ADDR;
            ADDR:    return MODE;
            MODE:    return (DUMMY_CLKS == 0) ? DATA : DUMMY;
            DUMMY:   return DATA;
            default: return DONE;
        endcase
    endfunction

    // Grants are withheld during reset so gnt reads 0 while HRESET is high.
    assign arb_en    = (state == IDLE) && !HRESET;
    assign arb_valid = |arb_gnt;

    flash_rr_arb u_arb (
        .clk    (HCLK),
        .rst    (HRESET),
        .req    ({bus.req1, bus.req0}),
        .enable (arb_en),
        .gnt    (arb_gnt),
        .port   (arb_port)
    );

    assign bus.gnt0    = arb_gnt[0];
    assign bus.gnt1    = arb_gnt[1];
    assign bus.rvalid0 = (state == DONE) && !port_q;
    assign bus.rvalid1 = (state == DONE) &&  port_q;
    assign bus.rdata   = rdata_q;

    // Sequencer state, SCK phase toggle and period counter.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
            ph    <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: each SCK period is a low then a high HCLK cycle; phases advance after the high half.
    always_comb begin
        state_n = state;
        ph_n    = ph;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                ph_n  = 1'b0;
                cnt_n = 8'd0;
                if (arb_valid) begin
                    state_n = CMD;
                end
            end
            CMD, ADDR, MODE, DUMMY, DATA: begin
                ph_n = ~ph;
                if (ph) begin
                    if (cnt == phase_len(state) - 8'd1) begin
                        cnt_n   = 8'd0;
                        state_n = next_phase(state);
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                ph_n    = 1'b0;
                cnt_n   = 8'd0;
                state_n = (CS_IDLE == 0) ? IDLE : GAP;
            end
            GAP: begin
                ph_n = 1'b0;
                if (cnt >= 8'(CS_IDLE - 1)) begin
                    cnt_n   = 8'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                ph_n    = 1'b0;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Pin values for the SCK period that is about to start.
    always_comb begin
        fdo_n  = 4'h0;
        fdoe_n = 4'h0;
        case (state_n)
            CMD: begin
                fdoe_n = 4'b0001;
                fdo_n  = {3'b000, CMD_QREAD[~cnt_n[2:0]]};
            end
            ADDR: begin
                fdoe_n = 4'hF;
                case (cnt_n[2:0])
                    3'd0:    fdo_n = addr_q[23:20];
                    3'd1:    fdo_n = addr_q[19:16];
                    3'd2:    fdo_n = addr_q[15:12];
                    3'd3:    fdo_n = addr_q[11:8];
                    3'd4:    fdo_n = addr_q[7:4];
                    default: fdo_n = addr_q[3:0];
                endcase
            end
            MODE: begin
                fdoe_n = 4'hF;
                fdo_n  = 4'h0;
            end
            default: ;
        endcase
    end

    // Latch the winning port and its word-aligned address on the grant cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            port_q <= 1'b0;
            addr_q <= 24'd0;
        end else if (arb_valid) begin
            port_q <= arb_port;
            addr_q <= (arb_port ? bus.addr1 : bus.addr0) & 24'hFFFFFC;
        end
    end

    // Registered flash pins; fdo/fdoe only move on edges that open a low SCK phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fsclk <= 1'b0;
            fcen  <= 1'b1;
            fdo   <= 4'h0;
            fdoe  <= 4'h0;
        end else begin
            fsclk <= is_active(state_n) && ph_n;
            fcen  <= !is_active(state_n);
            if (!ph_n) begin
                fdo  <= fdo_n;
                fdoe <= fdoe_n;
            end
        end
    end

    // Sample fdi at the end of each high phase in DATA; byte k high nibble first into rdata[8k+7:8k].
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rdata_q <= 32'd0;
        end else if ((state == DATA) && ph) begin
            rdata_q[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= fdi;
        end
    end

endmodule

// File: tb/tb_flash_rd_sched.sv
// Bench for flash_rd_sched: behavioural quad-SPI flash plus requester scoreboard.
module tb_flash_rd_sched;

    localparam int DUMMY      = 4;
    localparam int CSI        = 2;
    localparam int TOTAL_CLKS = 8 + 6 + 2 + DUMMY + 8;
    localparam int LAT        = 2 * TOTAL_CLKS + 1;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       fsclk;
    logic       fcen;
    logic [3:0] fdo;
    logic [3:0] fdoe;
    logic [3:0] fdi = 4'h0;

    flash_rd_sched_if bus ();

    flash_rd_sched #(.DUMMY_CLKS(DUMMY), .CS_IDLE(CSI)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus),
        .fsclk  (fsclk),
        .fcen   (fcen),
        .fdo    (fdo),
        .fdoe   (fdoe),
        .fdi    (fdi)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;
    int rr_last = 1;
    logic [31:0] last_rdata;

    // Flash memory and decoded view of the most recent transaction.
    logic [7:0]  mem [0:1023];
    int          m_r = 0;
    int          m_low = 0;
    int          m_hi_run = 0;
    int          m_gap = 0;
    int          m_bad = 0;
    int          m_idle_bad = 0;
    int          m_j;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic [23:0] m_tmp;
    logic [7:0]  m_byte;

    function automatic logic [3:0] oe_for(input int r);
        if (r < 8)  return 4'b0001;
        if (r < 16) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    // Flash model: evaluated mid-cycle; decodes on SCK high halves, presents data during low halves.
    always @(negedge HCLK) begin
        if (fcen) begin
            if (fsclk !== 1'b0 || fdoe !== 4'h0) m_idle_bad++;
            if (m_low != 0) begin
                m_r   = 0;
                m_low = 0;
            end
            m_hi_run++;
        end else begin
            if (m_low == 0) begin
                m_gap    = m_hi_run;
                m_hi_run = 0;
                m_cmd    = 8'h00;
                m_addr   = 24'h0;
                m_bad    = 0;
            end
            m_low++;
            if (fdoe !== oe_for(m_r)) m_bad++;
            if (m_r >= 14 && m_r < 16 && fdo !== 4'h0) m_bad++;
            if (fsclk) begin
                if (m_r < 8) m_cmd = {m_cmd[6:0], fdo[0]};
                else if (m_r < 14) m_addr = {m_addr[19:0], fdo};
                m_r++;
            end else if (m_r >= 20 && m_r < 28) begin
                m_j    = m_r - 20;
                m_tmp  = m_addr + 24'(m_j / 2);
                m_byte = mem[m_tmp[9:0]];
                fdi    = (m_j % 2 == 0) ? m_byte[7:4] : m_byte[3:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #2;
        HRESET = 1'b0;
        rr_last = 1;
    endtask

    // Drive n0/n1 requests (port 1 starts after d1 cycles) and score every grant and return.
    task automatic serve(input int n0, input int n1, input logic [23:0] a0, input logic [23:0] a1,
                         input int d1, input int maxc);
        int left [2];
        bit rq [2];
        bit gprev [2];
        logic [23:0] cur_a [2];
        bit busy;
        bit done;
        int g_port, g_cyc, prev_g, p, exp_p;
        logic [23:0] g_addr;
        left[0] = n0; left[1] = n1;
        cur_a[0] = a0; cur_a[1] = a1;
        rq[0] = 0; rq[1] = 0; gprev[0] = 0; gprev[1] = 0;
        busy = 0; done = 0; prev_g = -1; g_port = 0; g_cyc = 0; g_addr = 24'h0;
        for (int c = 0; c < maxc; c++) begin
            @(posedge HCLK);
            #1;
            for (int q = 0; q < 2; q++) begin
                if (gprev[q]) begin
                    gprev[q] = 0;
                    if (left[q] > 0) cur_a[q] = 24'($urandom);
                    rq[q] = (left[q] > 0);
                end else if (!rq[q] && left[q] > 0 && c >= ((q == 1) ? d1 : 0)) begin
                    rq[q] = 1;
                end
            end
            bus.req0 = rq[0]; bus.req1 = rq[1];
            bus.addr0 = cur_a[0]; bus.addr1 = cur_a[1];
            #1;
            if (bus.gnt0 || bus.gnt1) begin
                chk("gnt_excl", 64'(bus.gnt0 & bus.gnt1), 64'd0);
                p = bus.gnt1 ? 1 : 0;
                exp_p = (rq[0] && rq[1]) ? 1 - rr_last : (rq[0] ? 0 : 1);
                chk("gnt_port", 64'(p), 64'(exp_p));
                chk("gnt_while_busy", 64'(busy), 64'd0);
                if (prev_g >= 0) chk("gnt_spacing_ge60", 64'((c - prev_g) >= 60), 64'd1);
                rr_last = p; busy = 1; g_port = p; g_cyc = c; g_addr = cur_a[p];
                prev_g = c; left[p]--; gprev[p] = 1;
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                chk("rv_excl", 64'(bus.rvalid0 & bus.rvalid1), 64'd0);
                chk("rv_expected", 64'(busy), 64'd1);
                chk("rv_port", 64'(bus.rvalid1), 64'(g_port));
                chk("rv_latency", 64'(c - g_cyc), 64'(LAT));
                chk("rdata", 64'(bus.rdata), 64'(exp_word(g_addr)));
                chk("flash_cmd", 64'(m_cmd), 64'hEB);
                chk("flash_addr", 64'(m_addr), 64'(g_addr & 24'hFFFFFC));
                chk("fcen_low_cycles", 64'(m_low), 64'(2 * TOTAL_CLKS));
                chk("sck_highs", 64'(m_r), 64'(TOTAL_CLKS));
                chk("pin_pattern_errs", 64'(m_bad), 64'd0);
                chk("cs_gap_ge_idle", 64'(m_gap >= CSI), 64'd1);
                last_rdata = bus.rdata;
                busy = 0;
            end
            if (left[0] == 0 && left[1] == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $error("FAIL serve_timeout: got pending=%0d/%0d busy=%0d expected all served", left[0], left[1], busy);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        int seen;
        bit got;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 24'h0; bus.addr1 = 24'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;

        // Reset values, with both requests high during reset.
        repeat (3) @(posedge HCLK);
        #2;
        chk("rst_fcen", 64'(fcen), 64'd1);
        chk("rst_fsclk", 64'(fsclk), 64'd0);
        chk("rst_fdo", 64'(fdo), 64'd0);
        chk("rst_fdoe", 64'(fdoe), 64'd0);
        chk("rst_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
        chk("rst_rvalid", 64'({bus.rvalid1, bus.rvalid0}), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        HRESET = 1'b0;
        rr_last = 1;

        // Single read of the known word.
        serve(1, 0, 24'h000102, 24'h0, 0, 200);
        chk("single_word", 64'(last_rdata), 64'h44332211);

        // Tie straight out of reset.
        do_reset();
        serve(1, 1, 24'($urandom), 24'($urandom), 0, 300);

        // Sustained contention.
        serve(3, 3, 24'($urandom), 24'($urandom), 0, 600);

        // Late request on port 1.
        serve(1, 1, 24'($urandom), 24'($urandom), 20, 300);

        // Reset in the middle of the DATA phase.
        bus.addr0 = 24'($urandom);
        bus.req0 = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge HCLK);
            #2;
            if (bus.gnt0) begin
                got = 1;
                break;
            end
        end
        chk("midrst_gnt_seen", 64'(got), 64'd1);
        @(posedge HCLK);
        #1;
        bus.req0 = 1'b0;
        repeat (45) @(posedge HCLK);
        #2;
        chk("midrst_pre_fcen", 64'(fcen), 64'd0);
        chk("midrst_pre_fsclk", 64'(fsclk), 64'd1);
        HRESET = 1'b1;
        #1;
        chk("midrst_fcen", 64'(fcen), 64'd1);
        chk("midrst_fsclk", 64'(fsclk), 64'd0);
        chk("midrst_fdoe", 64'(fdoe), 64'd0);
        chk("midrst_fdo", 64'(fdo), 64'd0);
        chk("midrst_rdata", 64'(bus.rdata), 64'd0);
        repeat (2) @(posedge HCLK);
        #2;
        HRESET = 1'b0;
        rr_last = 1;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge HCLK);
            #2;
            if (bus.rvalid0 || bus.rvalid1) seen++;
        end
        chk("midrst_no_rvalid", 64'(seen), 64'd0);
        chk("midrst_idle_fcen", 64'(fcen), 64'd1);
        serve(1, 0, 24'($urandom), 24'h0, 0, 200);

        // Randomized mixes and single-port streams.
        for (int t = 0; t < 3; t++) begin
            serve(1 + $urandom_range(0, 2), $urandom_range(0, 2), 24'($urandom), 24'($urandom),
                  $urandom_range(0, 80), 900);
        end
        serve(0, 2, 24'h0, 24'($urandom), 0, 300);
        serve(2, 0, 24'($urandom), 24'h0, 0, 300);

        chk("idle_pins_errs", 64'(m_idle_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
